// File: rtl/mole_scheduler.sv
// mole_scheduler: places whack-a-mole targets into free holes,
// ages live moles and tallies hits, expiries and lost requests.
module mole_scheduler #(
   parameter int NUM_HOLES = 4,
   parameter int HOLE_W    = 2,
   parameter int LIFETIME  = 3,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 one_hz_enable,
   input  logic                 request_mole,
   input  logic [NUM_HOLES-1:0] hit,
   input  logic                 clear_board,
   output logic [NUM_HOLES-1:0] mole_active,
   output logic                 spawn_valid,
   output logic [HOLE_W-1:0]    spawn_hole,
   output logic [CNT_W-1:0]     score,
   output logic [CNT_W-1:0]     misses,
   output logic [CNT_W-1:0]     dropped,
   output logic                 busy
);

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t               state_q, state_d;
   logic [7:0]           lfsr_q, lfsr_d;
   logic                 pend_q, pend_d;
   logic [HOLE_W-1:0]    probe_q, probe_d;
   logic [HOLE_W-1:0]    tries_q, tries_d;
   logic [NUM_HOLES-1:0] mole_q, mole_d;
   logic [3:0]           timer_q [NUM_HOLES];
   logic [3:0]           timer_d [NUM_HOLES];
   logic [CNT_W-1:0]     score_q, score_d;
   logic [CNT_W-1:0]     misses_q, misses_d;
   logic [CNT_W-1:0]     dropped_q, dropped_d;
   logic                 spawn_q, spawn_d;
   logic [HOLE_W-1:0]    hole_q, hole_d;
   logic [NUM_HOLES-1:0] hits, expire;
   logic [1:0]           drop_ev;

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0]     a,
      input logic [NUM_HOLES-1:0] v
   );
      logic [CNT_W:0] s;
      s = {1'b0, a};
      for (int i = 0; i < NUM_HOLES; i++)
         s = s + {{CNT_W{1'b0}}, v[i]};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign lfsr_d = {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      hits   = hit & mole_q;
      expire = '0;
      for (int i = 0; i < NUM_HOLES; i++)
         expire[i] = one_hz_enable & mole_q[i] & ~hits[i]
                   & (timer_q[i] == 4'd1);
      mole_d = mole_q & ~hits & ~expire;
      for (int i = 0; i < NUM_HOLES; i++) begin
         timer_d[i] = timer_q[i];
         if (hits[i] | expire[i])
            timer_d[i] = '0;
         else if (one_hz_enable & mole_q[i])
            timer_d[i] = timer_q[i] - 4'd1;
      end

      state_d = state_q;
      probe_d = probe_q;
      tries_d = tries_q;
      pend_d  = pend_q;
      spawn_d = 1'b0;
      hole_d  = hole_q;
      drop_ev = '0;

      unique case (state_q)
         IDLE: begin
            if (request_mole | pend_q) begin
               // a fresh request arriving with one already latched is lost
               drop_ev[0] = request_mole & pend_q;
               pend_d     = 1'b0;
               state_d    = SEARCH;
               probe_d    = lfsr_q[HOLE_W-1:0];
               tries_d    = '0;
            end
         end
         SEARCH: begin
            drop_ev[0] = request_mole & pend_q;
            pend_d     = pend_q | request_mole;
            if (!mole_q[probe_q]) begin
               mole_d[probe_q]  = 1'b1;
               timer_d[probe_q] = 4'(LIFETIME);
               spawn_d          = 1'b1;
               hole_d           = probe_q;
               state_d          = IDLE;
            end else if (tries_q == HOLE_W'(NUM_HOLES - 1)) begin
               drop_ev[1] = 1'b1;
               state_d    = IDLE;
            end else begin
               probe_d = probe_q + HOLE_W'(1);
               tries_d = tries_q + HOLE_W'(1);
            end
         end
      endcase

      score_d   = sat_add(score_q, hits);
      misses_d  = sat_add(misses_q, expire);
      dropped_d = sat_add(dropped_q, NUM_HOLES'(drop_ev));

      if (clear_board) begin
         mole_d    = '0;
         pend_d    = 1'b0;
         spawn_d   = 1'b0;
         state_d   = IDLE;
         score_d   = '0;
         misses_d  = '0;
         dropped_d = '0;
         for (int i = 0; i < NUM_HOLES; i++)
            timer_d[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         lfsr_q    <= 8'h01;
         pend_q    <= 1'b0;
         probe_q   <= '0;
         tries_q   <= '0;
         mole_q    <= '0;
         score_q   <= '0;
         misses_q  <= '0;
         dropped_q <= '0;
         spawn_q   <= 1'b0;
         hole_q    <= '0;
         for (int i = 0; i < NUM_HOLES; i++)
            timer_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         pend_q    <= pend_d;
         probe_q   <= probe_d;
         tries_q   <= tries_d;
         mole_q    <= mole_d;
         score_q   <= score_d;
         misses_q  <= misses_d;
         dropped_q <= dropped_d;
         spawn_q   <= spawn_d;
         hole_q    <= hole_d;
         for (int i = 0; i < NUM_HOLES; i++)
            timer_q[i] <= timer_d[i];
      end
   end

   assign mole_active = mole_q;
   assign spawn_valid = spawn_q;
   assign spawn_hole  = hole_q;
   assign score       = score_q;
   assign misses      = misses_q;
   assign dropped     = dropped_q;
   assign busy        = (state_q == SEARCH);

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: reference model of the board compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mole_scheduler;

   localparam int N    = 4;
   localparam int HW   = 2;
   localparam int LIFE = 3;
   localparam int CW   = 8;
   localparam int MAXC = 255;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          one_hz = 1'b0;
   logic          req = 1'b0;
   logic          clr = 1'b0;
   logic [N-1:0]  hit = '0;
   logic [N-1:0]  mole_active;
   logic          spawn_valid;
   logic [HW-1:0] spawn_hole;
   logic [CW-1:0] score, misses, dropped;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int h, ok, nsp;
   int hs [2];

   // reference model state
   int         life [N];
   int         m_score, m_miss, m_drop;
   bit         m_search, m_pend, m_sv;
   int         m_probe, m_tries, m_sh;
   logic [7:0] m_lfsr = 8'h01;

   mole_scheduler #(
      .NUM_HOLES(N), .HOLE_W(HW), .LIFETIME(LIFE), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .one_hz_enable(one_hz),
      .request_mole(req),
      .hit(hit),
      .clear_board(clr),
      .mole_active(mole_active),
      .spawn_valid(spawn_valid),
      .spawn_hole(spawn_hole),
      .score(score),
      .misses(misses),
      .dropped(dropped),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   function automatic logic [N-1:0] m_mask();
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++)
         if (life[i] > 0) m[i] = 1'b1;
      return m;
   endfunction

   // model: a hole is up while its remaining life is positive
   initial begin
      for (int i = 0; i < N; i++) life[i] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < N; i++) life[i] = 0;
            m_score = 0; m_miss = 0; m_drop = 0;
            m_search = 0; m_pend = 0; m_sv = 0;
            m_probe = 0; m_tries = 0; m_sh = 0;
            m_lfsr = 8'h01;
         end else begin
            bit was_up [N];
            int add_s, add_m, add_d;
            add_s = 0; add_m = 0; add_d = 0;
            m_sv = 0;
            for (int i = 0; i < N; i++) was_up[i] = life[i] > 0;
            if (clr) begin
               for (int i = 0; i < N; i++) life[i] = 0;
               m_score = 0; m_miss = 0; m_drop = 0;
               m_search = 0; m_pend = 0;
            end else begin
               for (int i = 0; i < N; i++) begin
                  if (hit[i] && was_up[i]) begin
                     life[i] = 0;
                     add_s++;
                  end else if (one_hz && was_up[i]) begin
                     life[i]--;
                     if (life[i] == 0) add_m++;
                  end
               end
               if (!m_search) begin
                  if (req || m_pend) begin
                     if (req && m_pend) add_d++;
                     m_pend   = 0;
                     m_search = 1;
                     m_probe  = m_lfsr % N;
                     m_tries  = 0;
                  end
               end else begin
                  if (req) begin
                     if (m_pend) add_d++;
                     else m_pend = 1;
                  end
                  if (!was_up[m_probe]) begin
                     life[m_probe] = LIFE;
                     m_sv = 1;
                     m_sh = m_probe;
                     m_search = 0;
                  end else if (m_tries == N - 1) begin
                     add_d++;
                     m_search = 0;
                  end else begin
                     m_probe = (m_probe + 1) % N;
                     m_tries++;
                  end
               end
               m_score = sat(m_score + add_s);
               m_miss  = sat(m_miss + add_m);
               m_drop  = sat(m_drop + add_d);
            end
            m_lfsr = {m_lfsr[6:0],
                      m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("mdl_active", int'(mole_active), int'(m_mask()));
         chk("mdl_spawn_valid", int'(spawn_valid), int'(m_sv));
         if (m_sv) chk("mdl_spawn_hole", int'(spawn_hole), m_sh);
         chk("mdl_score", int'(score), m_score);
         chk("mdl_misses", int'(misses), m_miss);
         chk("mdl_dropped", int'(dropped), m_drop);
         chk("mdl_busy", int'(busy), int'(m_search));
      end
   end

   task automatic pulse_req();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic tick(input logic [N-1:0] hv);
      one_hz = 1'b1;
      hit = hv;
      @(negedge clk);
      one_hz = 1'b0;
      hit = '0;
   endtask

   task automatic wait_spawn(output int hole, output int seen);
      seen = 0;
      hole = 0;
      for (int i = 0; i < 6 && seen == 0; i++) begin
         @(negedge clk);
         if (spawn_valid) begin
            seen = 1;
            hole = int'(spawn_hole);
         end
      end
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_active"}, int'(mole_active), 0);
      chk({nm, "_spawn"}, int'(spawn_valid), 0);
      chk({nm, "_score"}, int'(score), 0);
      chk({nm, "_misses"}, int'(misses), 0);
      chk({nm, "_dropped"}, int'(dropped), 0);
      chk({nm, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      // T1: random inputs under reset
      repeat (4) begin
         @(negedge clk);
         one_hz = 1'($urandom);
         req    = 1'($urandom);
         clr    = 1'($urandom);
         hit    = 4'($urandom);
      end
      @(negedge clk);
      all_zero("t1_rst");
      one_hz = 1'b0; req = 1'b0; clr = 1'b0; hit = '0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      pulse_req();
      wait_spawn(h, ok);
      chk("t1_spawn_seen", ok, 1);
      chk("t1_onehot", int'(mole_active), 1 << h);

      // T2: expiry on third tick
      tick('0);
      tick('0);
      chk("t2_alive", int'(mole_active), 1 << h);
      tick('0);
      chk("t2_active", int'(mole_active), 0);
      chk("t2_misses", int'(misses), 1);
      chk("t2_score", int'(score), 0);

      // T3: hit live hole, held hit, hit on empty board
      pulse_req();
      wait_spawn(h, ok);
      chk("t3_spawn_seen", ok, 1);
      hit = 4'(1 << h);
      @(negedge clk);
      chk("t3_cleared", int'(mole_active), 0);
      chk("t3_score", int'(score), 1);
      repeat (2) @(negedge clk);
      hit = '0;
      chk("t3_held", int'(score), 1);
      hit = 4'hf;
      repeat (2) @(negedge clk);
      hit = '0;
      chk("t3_empty_hit", int'(score), 1);

      // hit and expiry on the same hole in the same cycle
      pulse_req();
      wait_spawn(h, ok);
      chk("t3b_spawn_seen", ok, 1);
      tick('0);
      tick('0);
      tick(4'(1 << h));
      chk("t3b_score", int'(score), 2);
      chk("t3b_misses", int'(misses), 1);
      chk("t3b_active", int'(mole_active), 0);

      // T4: full board drop
      repeat (N) begin
         pulse_req();
         wait_spawn(h, ok);
         chk("t4_fill", ok, 1);
      end
      chk("t4_full", int'(mole_active), 4'hf);
      pulse_req();
      chk("t4_busy", int'(busy), 1);
      nsp = 0;
      repeat (5) begin
         @(negedge clk);
         if (spawn_valid) nsp++;
      end
      chk("t4_nospawn", nsp, 0);
      chk("t4_dropped", int'(dropped), 1);
      chk("t4_idle", int'(busy), 0);

      // dropped saturates under a stream of requests
      req = 1'b1;
      repeat (600) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("sat_dropped", int'(dropped), MAXC);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      all_zero("clr");

      // T5: three back-to-back requests on an empty board
      nsp = 0;
      hs[0] = 0;
      hs[1] = 0;
      for (int i = 0; i < 13; i++) begin
         req = (i < 3);
         @(negedge clk);
         if (spawn_valid) begin
            if (nsp < 2) hs[nsp] = int'(spawn_hole);
            nsp++;
         end
      end
      req = 1'b0;
      chk("t5_spawns", nsp, 2);
      chk("t5_distinct", int'(hs[0] != hs[1]), 1);
      chk("t5_dropped", int'(dropped), 1);
      chk("t5_active", int'(mole_active), (1 << hs[0]) | (1 << hs[1]));

      // T6a: clear_board during a search with three moles up
      pulse_req();
      wait_spawn(h, ok);
      chk("t6a_fill", ok, 1);
      pulse_req();
      chk("t6a_busy", int'(busy), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      all_zero("t6a");
      nsp = 0;
      repeat (3) begin
         @(negedge clk);
         if (spawn_valid) nsp++;
      end
      chk("t6a_nospawn", nsp, 0);

      // T6b: reset during a search with three moles up
      repeat (3) begin
         pulse_req();
         wait_spawn(h, ok);
         chk("t6b_fill", ok, 1);
      end
      tick(4'(1 << h));
      pulse_req();
      wait_spawn(h, ok);
      chk("t6b_refill", ok, 1);
      pulse_req();
      chk("t6b_busy", int'(busy), 1);
      chk("t6b_score", int'(score), 1);
      #2 rst_n = 1'b0;
      #1 all_zero("t6b");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      nsp = 0;
      repeat (4) begin
         @(negedge clk);
         if (spawn_valid) nsp++;
      end
      chk("t6b_nospawn", nsp, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
